// File: rtl/dispenser_pkg.sv
// Shared state encodings and default tick constants for the cup/coffee dispenser.
package dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DROP  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HELD  = 3'd3,
    ST_POUR  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  localparam int DEF_CNT_W         = 8;
  localparam int DEF_CUP_TICKS     = 16;
  localparam int DEF_POUR_TICKS    = 32;
  localparam int DEF_TIMEOUT_TICKS = 64;

endpackage

// File: rtl/dispense_timer.sv
// Tick counter with synchronous clear; o_hit flags the last cycle of a limit-long interval.
module dispense_timer
  import dispenser_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  // Compare is done CNT_W bits wide so a limit of 1 hits on count 0.
  assign w_last = i_limit - CNT_W'(1);
  assign o_hit  = (r_cnt == w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cup_coffee_dispenser.sv
// Mechanism-side responder: drops a cup, checks it, pours, and answers the
// controller's 4-phase cup/coffee handshake with Moore outputs.
module cup_coffee_dispenser
  import dispenser_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int CUP_TICKS     = DEF_CUP_TICKS,
  parameter int POUR_TICKS    = DEF_POUR_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic clk,
  input  logic RST,
  input  logic place_cup,
  input  logic Release_cof,
  input  logic cup_sensor,
  output logic cup_motor,
  output logic valve_open,
  output logic cup_rdy,
  output logic cof_rdy,
  output logic busy,
  output logic fault
);

  localparam logic [CNT_W-1:0] L_CUP  = CNT_W'(CUP_TICKS);
  localparam logic [CNT_W-1:0] L_POUR = CNT_W'(POUR_TICKS);
  localparam logic [CNT_W-1:0] L_TMO  = CNT_W'(TIMEOUT_TICKS);

  state_t           r_state;
  logic             r_place;
  logic             r_rel;
  logic             r_sens_s1;
  logic             r_sens_s2;
  logic             w_hit;
  logic             w_clr;
  logic [CNT_W-1:0] w_limit;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_place   <= 1'b0;
      r_rel     <= 1'b0;
      r_sens_s1 <= 1'b0;
      r_sens_s2 <= 1'b0;
    end else begin
      r_place   <= place_cup;
      r_rel     <= Release_cof;
      r_sens_s1 <= cup_sensor;
      r_sens_s2 <= r_sens_s1;
    end
  end

  // Timer is held at zero outside timed states and cleared on any exit,
  // so every timed state starts counting from 0.
  always_comb begin
    w_limit = L_CUP;
    w_clr   = 1'b1;
    case (r_state)
      ST_DROP: begin
        w_limit = L_CUP;
        w_clr   = w_hit;
      end
      ST_CHECK: begin
        w_limit = L_TMO;
        w_clr   = r_sens_s2 | w_hit;
      end
      ST_POUR: begin
        w_limit = L_POUR;
        w_clr   = ~r_sens_s2 | w_hit;
      end
      default: ;
    endcase
  end

  dispense_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (RST),
    .i_clr   (w_clr),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (r_place) r_state <= ST_DROP;
        ST_DROP:  if (w_hit) r_state <= ST_CHECK;
        ST_CHECK: begin
          if (r_sens_s2)  r_state <= ST_HELD;
          else if (w_hit) r_state <= ST_FAULT;
        end
        ST_HELD: begin
          if (!r_sens_s2) r_state <= ST_FAULT;
          else if (r_rel) r_state <= ST_POUR;
        end
        ST_POUR: begin
          if (!r_sens_s2) r_state <= ST_FAULT;
          else if (w_hit) r_state <= ST_DONE;
        end
        ST_DONE:  if (!r_rel) r_state <= ST_IDLE;
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cup_motor  = 1'b0;
    valve_open = 1'b0;
    cup_rdy    = 1'b0;
    cof_rdy    = 1'b0;
    busy       = 1'b0;
    fault      = 1'b0;
    case (r_state)
      ST_DROP: begin
        cup_motor = 1'b1;
        busy      = 1'b1;
      end
      ST_CHECK: busy = 1'b1;
      ST_HELD: begin
        cup_rdy = 1'b1;
        busy    = 1'b1;
      end
      ST_POUR: begin
        cup_rdy    = 1'b1;
        valve_open = 1'b1;
        busy       = 1'b1;
      end
      ST_DONE: begin
        cup_rdy = 1'b1;
        cof_rdy = 1'b1;
        busy    = 1'b1;
      end
      ST_FAULT: begin
        fault = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cup_coffee_dispenser.sv
// Scoreboard bench: expected output runs (vector + length in cycles) are queued by
// the stimulus and compared by per-instance monitors whenever the outputs change.
module tb_cup_coffee_dispenser;

  localparam logic [5:0] V_IDLE  = 6'b000000;
  localparam logic [5:0] V_DROP  = 6'b010001;
  localparam logic [5:0] V_CHECK = 6'b010000;
  localparam logic [5:0] V_HELD  = 6'b010100;
  localparam logic [5:0] V_POUR  = 6'b010110;
  localparam logic [5:0] V_DONE  = 6'b011100;
  localparam logic [5:0] V_FAULT = 6'b110000;

  typedef struct {
    logic [5:0] vec;
    int         len;
    string      nm;
  } run_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: default parameters
  logic a_rst, a_place, a_rel, a_sens;
  logic a_motor, a_valve, a_cup_rdy, a_cof_rdy, a_busy, a_fault;
  logic [5:0] a_vec;
  assign a_vec = {a_fault, a_busy, a_cof_rdy, a_cup_rdy, a_valve, a_motor};

  cup_coffee_dispenser u_dut_a (
    .clk         (clk),
    .RST         (a_rst),
    .place_cup   (a_place),
    .Release_cof (a_rel),
    .cup_sensor  (a_sens),
    .cup_motor   (a_motor),
    .valve_open  (a_valve),
    .cup_rdy     (a_cup_rdy),
    .cof_rdy     (a_cof_rdy),
    .busy        (a_busy),
    .fault       (a_fault)
  );

  // Instance B: one-tick drop and pour
  logic b_rst, b_place, b_rel, b_sens;
  logic b_motor, b_valve, b_cup_rdy, b_cof_rdy, b_busy, b_fault;
  logic [5:0] b_vec;
  assign b_vec = {b_fault, b_busy, b_cof_rdy, b_cup_rdy, b_valve, b_motor};

  cup_coffee_dispenser #(
    .CUP_TICKS  (1),
    .POUR_TICKS (1)
  ) u_dut_b (
    .clk         (clk),
    .RST         (b_rst),
    .place_cup   (b_place),
    .Release_cof (b_rel),
    .cup_sensor  (b_sens),
    .cup_motor   (b_motor),
    .valve_open  (b_valve),
    .cup_rdy     (b_cup_rdy),
    .cof_rdy     (b_cof_rdy),
    .busy        (b_busy),
    .fault       (b_fault)
  );

  run_t       a_q[$];
  run_t       b_q[$];
  run_t       a_e;
  run_t       b_e;
  logic [5:0] a_cur = 6'b0;
  logic [5:0] b_cur = 6'b0;
  int         a_len = 0;
  int         b_len = 0;

  // len == 0 in an expected run means the length is not checked.
  always @(negedge clk) begin
    if (a_vec !== a_cur) begin
      checks++;
      if (a_q.size() == 0) begin
        failures++;
        $display("FAIL a_extra: outputs changed %b -> %b with no expected run", a_cur, a_vec);
      end else begin
        a_e = a_q.pop_front();
        if (a_e.vec !== a_cur || (a_e.len != 0 && a_e.len != a_len)) begin
          failures++;
          $display("FAIL a_%s: got vec=%b len=%0d, expected vec=%b len=%0d",
                   a_e.nm, a_cur, a_len, a_e.vec, a_e.len);
        end
      end
      a_cur = a_vec;
      a_len = 1;
    end else begin
      a_len++;
    end
  end

  always @(negedge clk) begin
    if (b_vec !== b_cur) begin
      checks++;
      if (b_q.size() == 0) begin
        failures++;
        $display("FAIL b_extra: outputs changed %b -> %b with no expected run", b_cur, b_vec);
      end else begin
        b_e = b_q.pop_front();
        if (b_e.vec !== b_cur || (b_e.len != 0 && b_e.len != b_len)) begin
          failures++;
          $display("FAIL b_%s: got vec=%b len=%0d, expected vec=%b len=%0d",
                   b_e.nm, b_cur, b_len, b_e.vec, b_e.len);
        end
      end
      b_cur = b_vec;
      b_len = 1;
    end else begin
      b_len++;
    end
  end

  task automatic exp_a(input logic [5:0] v, input int l, input string nm);
    run_t r;
    r.vec = v; r.len = l; r.nm = nm;
    a_q.push_back(r);
  endtask

  task automatic exp_b(input logic [5:0] v, input int l, input string nm);
    run_t r;
    r.vec = v; r.len = l; r.nm = nm;
    b_q.push_back(r);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_a_zero(input string nm);
    #1;
    checks++;
    if (a_vec !== V_IDLE) begin
      failures++;
      $display("FAIL %s: outputs=%b right after RST, expected %b", nm, a_vec, V_IDLE);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_place = 1'b0; a_rel = 1'b0; a_sens = 1'b0;
    b_rst = 1'b1; b_place = 1'b0; b_rel = 1'b0; b_sens = 1'b0;
    exp_a(V_IDLE, 0, "reset_idle");
    exp_b(V_IDLE, 0, "reset_idle");
    cyc(3);
    a_rst = 1'b0;
    cyc(2);

    // Nominal cycle: drop, sensor confirms, pour, release
    exp_a(V_DROP, 16, "nom_drop");
    exp_a(V_CHECK, 1, "nom_check");
    exp_a(V_HELD, 3, "nom_held");
    exp_a(V_POUR, 32, "nom_pour");
    exp_a(V_DONE, 8, "nom_done");
    exp_a(V_IDLE, 0, "nom_idle");
    a_place = 1'b1;
    cyc(10); a_sens = 1'b1;
    cyc(10); a_place = 1'b0; a_rel = 1'b1;
    cyc(40); a_rel = 1'b0; a_sens = 1'b0;
    cyc(5);

    // No cup: timeout in CHECK leads to sticky fault
    exp_a(V_DROP, 16, "nocup_drop");
    exp_a(V_CHECK, 64, "nocup_check");
    exp_a(V_FAULT, 0, "nocup_fault");
    a_place = 1'b1;
    cyc(3); a_place = 1'b0;
    cyc(100);
    exp_a(V_IDLE, 0, "nocup_rst_idle");
    a_rst = 1'b1;
    cyc(2); a_rst = 1'b0;
    cyc(3);

    // Cup removed on pour cycle 10
    exp_a(V_DROP, 16, "rm_drop");
    exp_a(V_CHECK, 1, "rm_check");
    exp_a(V_HELD, 3, "rm_held");
    exp_a(V_POUR, 12, "rm_pour");
    exp_a(V_FAULT, 0, "rm_fault");
    a_sens = 1'b1; a_place = 1'b1;
    cyc(20); a_place = 1'b0; a_rel = 1'b1;
    cyc(11); a_sens = 1'b0;
    cyc(5);  a_rel = 1'b0;
    cyc(3);
    exp_a(V_IDLE, 0, "rm_rst_idle");
    a_rst = 1'b1;
    cyc(2); a_rst = 1'b0;

    // Release alone is ignored; then both high: drop first, pour right after HELD
    a_sens = 1'b1; a_rel = 1'b1;
    cyc(10);
    exp_a(V_DROP, 16, "both_drop");
    exp_a(V_CHECK, 1, "both_check");
    exp_a(V_HELD, 1, "both_held");
    exp_a(V_POUR, 32, "both_pour");
    exp_a(V_DONE, 10, "both_done");
    exp_a(V_IDLE, 0, "both_idle");
    a_place = 1'b1;
    cyc(60); a_rel = 1'b0; a_place = 1'b0;
    cyc(5);

    // Reset mid-DROP
    exp_a(V_DROP, 4, "rstd_drop");
    exp_a(V_IDLE, 0, "rstd_idle");
    a_place = 1'b1;
    cyc(6); a_rst = 1'b1; a_place = 1'b0;
    chk_a_zero("rst_mid_drop");
    cyc(2); a_rst = 1'b0;
    cyc(3);

    // Reset mid-POUR
    exp_a(V_DROP, 16, "rstp_drop");
    exp_a(V_CHECK, 1, "rstp_check");
    exp_a(V_HELD, 3, "rstp_held");
    exp_a(V_POUR, 8, "rstp_pour");
    exp_a(V_IDLE, 0, "rstp_idle");
    a_place = 1'b1;
    cyc(20); a_place = 1'b0; a_rel = 1'b1;
    cyc(10); a_rst = 1'b1;
    chk_a_zero("rst_mid_pour");
    cyc(2); a_rst = 1'b0; a_rel = 1'b0;
    cyc(5);

    // One-tick drop and pour on instance B
    b_rst = 1'b0; b_sens = 1'b1;
    cyc(3);
    exp_b(V_DROP, 1, "tick_drop");
    exp_b(V_CHECK, 1, "tick_check");
    exp_b(V_HELD, 1, "tick_held");
    exp_b(V_POUR, 1, "tick_pour");
    exp_b(V_DONE, 6, "tick_done");
    exp_b(V_IDLE, 0, "tick_idle");
    b_place = 1'b1; b_rel = 1'b1;
    cyc(10); b_place = 1'b0; b_rel = 1'b0;
    cyc(5);

    // Only the open-ended final IDLE run may remain on each scoreboard
    checks++;
    if (a_q.size() != 1 || a_cur !== V_IDLE) begin
      failures++;
      $display("FAIL a_drain: pending=%0d cur=%b, expected pending=1 cur=%b", a_q.size(), a_cur, V_IDLE);
    end
    checks++;
    if (b_q.size() != 1 || b_cur !== V_IDLE) begin
      failures++;
      $display("FAIL b_drain: pending=%0d cur=%b, expected pending=1 cur=%b", b_q.size(), b_cur, V_IDLE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
